// File: rtl/timer_top.sv
// Down-counting timer peripheral with prescaler, auto-reload and a
// sticky expiry flag that drives a level interrupt.
module timer_top #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        Done
);

    logic             en_q, en_d;
    logic             ar_q, ar_d;
    logic             ie_q, ie_d;
    logic             exp_q, exp_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic wr_ctrl, wr_load, wr_stat;
    logic pre_hit, tick, expire;

    assign wr_ctrl = WE && (A == 2'd0);
    assign wr_load = WE && (A == 2'd1);
    assign wr_stat = WE && (A == 2'd3);

    // A LOAD write on the tick edge swallows the tick entirely
    assign pre_hit = (pcnt_q == pre_q);
    assign tick    = en_q && pre_hit && !wr_load;
    assign expire  = tick && (count_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            exp_q   <= 1'b0;
            pre_q   <= '0;
            pcnt_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
        end else begin
            en_q    <= en_d;
            ar_q    <= ar_d;
            ie_q    <= ie_d;
            exp_q   <= exp_d;
            pre_q   <= pre_d;
            pcnt_q  <= pcnt_d;
            load_q  <= load_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        en_d    = en_q;
        ar_d    = ar_q;
        ie_d    = ie_q;
        exp_d   = exp_q;
        pre_d   = pre_q;
        pcnt_d  = pcnt_q;
        load_d  = load_q;
        count_d = count_q;

        if (en_q) begin
            pcnt_d = pre_hit ? '0 : pcnt_q + PRE_W'(1);
        end

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else if (ar_q) begin
                count_d = load_q;
            end
        end

        // Set after clear so an expiry racing a W1C is never lost
        if (wr_stat && WD[0]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
            if (!ar_q) begin
                en_d = 1'b0;
            end
        end

        if (wr_ctrl) begin
            en_d  = WD[0];
            ar_d  = WD[1];
            ie_d  = WD[2];
            pre_d = WD[8 +: PRE_W];
            if (!en_q && WD[0]) begin
                pcnt_d = '0;
            end
        end

        if (wr_load) begin
            load_d  = WD[CNT_W-1:0];
            count_d = WD[CNT_W-1:0];
            pcnt_d  = '0;
        end
    end

    always_comb begin
        RD = '0;
        unique case (A)
            2'd0: begin
                RD[0]           = en_q;
                RD[1]           = ar_q;
                RD[2]           = ie_q;
                RD[8 +: PRE_W]  = pre_q;
            end
            2'd1: RD[CNT_W-1:0] = load_q;
            2'd2: RD[CNT_W-1:0] = count_q;
            2'd3: begin
                RD[0] = exp_q;
                RD[1] = en_q;
            end
        endcase
    end

    assign Done = exp_q & ie_q;

endmodule
